truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//   Hardware stimulus/response end for the 4-input combinational exercise blocks.
//   On start, drives every input vector {a,b,c,d} = 0..15 in ascending order.
//   Holds each vector for HOLD_CYCLES clocks and samples the DUT output y once per vector.
//   Assembles the captured truth table and compares it against an expected table.
//   Reports pass/fail and a per-row error mask. Sits on-board between a trigger and the DUT.
// PARAMETERS
//   N_IN         4   number of DUT inputs; table width TT_W = 2**N_IN
//   HOLD_CYCLES  5   clocks each vector is held (>=1); y sampled on the last held cycle
// PORTS
//   clk       in   1     system clock, rising edge
//   rst_n     in   1     asynchronous, active-low reset
//   start     in   1     one-cycle request to begin a sweep; ignored while busy
//   expected  in   TT_W  expected truth table, bit i = y for input vector i; latched on start
//   vec_out   out  N_IN  drive to DUT inputs, MSB = a ... LSB = d
//   y_in      in   1     DUT output, same clock domain, no synchroniser
//   busy      out  1     high from start acceptance until done
//   done      out  1     one-cycle pulse, results valid
//   pass      out  1     1 when captured table == expected; held until next start
//   tt_out    out  TT_W  captured truth table; held until next start
//   err_mask  out  TT_W  tt_out ^ expected; held until next start
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, vec_out=0, busy=0, done=0, pass=0,
//     tt_out=0, err_mask=0, hold counter=0, latched expected=0.
//   FSM states:
//     IDLE   - start=1 -> SWEEP; latch expected; vec_out=0; clear tt_out/pass/err_mask; busy=1
//     SWEEP  - hold_cnt counts 0..HOLD_CYCLES-1.
//              At hold_cnt==HOLD_CYCLES-1: tt_out[vec_out] <= y_in.
//              If vec_out==TT_W-1 -> REPORT, else vec_out+1 and hold_cnt=0.
//     REPORT - one cycle: pass <= (tt_out==exp_q), err_mask <= tt_out^exp_q,
//              done=1, busy=0 -> IDLE. vec_out stays at TT_W-1 until next start.
//   Timing: start sampled at edge k. Vector i is driven from edge k+i*H,
//     with H=HOLD_CYCLES, and sampled at edge k+(i+1)*H.
//     done is high for the cycle after edge k+TT_W*H+1 (81 edges for the defaults).
//   start while busy: ignored; expected is not re-latched.
//   start in the REPORT cycle: ignored. start in the same cycle done is high: accepted.
//   Reset mid-sweep: immediate return to reset values; no done pulse; partial table discarded.
//   done is never high together with busy.
//   vec_out wraps nowhere: the sweep ends at TT_W-1.
//   Counter widths: hold_cnt $clog2(HOLD_CYCLES+1); vec_out N_IN.
// STRUCTURE
//   Shared header tt_defs.vh: FSM state localparams (IDLE=2'd0, SWEEP=2'd1, REPORT=2'd2),
//     and TT_W derivation macro.
//   One sub-module, hold_timer: parameterised down/up counter with clear and terminal-count output.
//     Used for the per-vector hold.
//   FSM, capture register and compare stay in the top module.
// TESTING
//   1. y_in = ^vec_out, expected=16'h6996, start pulse
//      -> busy 80 cycles, done at edge k+81, pass=1, tt_out=16'h6996, err_mask=0.
//   2. y_in = &vec_out, expected=16'h8000 -> pass=1, tt_out=16'h8000.
//   3. y_in tied 0, expected=16'h6996 -> pass=0, tt_out=0, err_mask=16'h6996.
//   4. rst_n low at edge k+40 mid-sweep -> all outputs 0 immediately, no done.
//      A new start then runs a full 81-cycle sweep.
//   5. Second start plus expected=16'hFFFF while busy (case 1)
//      -> ignored; result pass=1 versus the original 16'h6996; exactly one done pulse.
//   6. HOLD_CYCLES=1, y_in=^vec_out -> vec_out steps every clock, done at edge k+17, pass=1.
//   All cases: check vec_out holds each value exactly HOLD_CYCLES clocks, in order 0..15.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: FSM encoding and truth-table width helper shared by the sweeper files
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        REPORT = 2'd2
    } state_e;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// hold_timer: counts 0..HOLD-1 while enabled, flags the last held cycle, wraps to 0
module hold_timer #(
    parameter int HOLD = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(HOLD + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == CW'(HOLD - 1));

    // clear wins; on terminal count restart for the next vector
    always_comb begin
        cnt_d = clr ? '0 : (en ? (tc ? '0 : cnt_q + 1'b1) : cnt_q);
    end

    // hold counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all input vectors to a 4-input block, captures y and grades it against a table
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int HOLD_CYCLES = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [tt_width(N_IN)-1:0]   expected,
    output logic [N_IN-1:0]             vec_out,
    input  logic                        y_in,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [tt_width(N_IN)-1:0]   tt_out,
    output logic [tt_width(N_IN)-1:0]   err_mask
);

    localparam int TT_W = tt_width(N_IN);
    localparam logic [N_IN-1:0] LAST = N_IN'(TT_W - 1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [TT_W-1:0] tt_q, tt_d, exp_q, exp_d, err_q, err_d;
    logic            pass_q, pass_d, done_q, done_d;
    logic            go, tc;

    assign go = (state_q == IDLE) && start;

    hold_timer #(.HOLD(HOLD_CYCLES)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != SWEEP),
        .en    (state_q == SWEEP),
        .tc    (tc)
    );

    // state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            tt_q    <= '0;
            exp_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            tt_q    <= tt_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    // sweep sequencing: idle until start, sweep all vectors, one grading cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SWEEP : IDLE;
            SWEEP:   state_d = (tc && vec_q == LAST) ? REPORT : SWEEP;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // vector stepping, capture on the last held cycle, grading in REPORT
    always_comb begin
        vec_d  = vec_q;
        tt_d   = tt_q;
        exp_d  = exp_q;
        err_d  = err_q;
        pass_d = pass_q;
        done_d = 1'b0;
        if (go) begin
            vec_d  = '0;
            tt_d   = '0;
            exp_d  = expected;
            err_d  = '0;
            pass_d = 1'b0;
        end else if (tc) begin
            tt_d[vec_q] = y_in;
            vec_d       = (vec_q == LAST) ? vec_q : vec_q + 1'b1;
        end else if (state_q == REPORT) begin
            pass_d = (tt_q == exp_q);
            err_d  = tt_q ^ exp_q;
            done_d = 1'b1;
        end
    end

    assign vec_out  = vec_q;
    assign busy     = (state_q == SWEEP);
    assign done     = done_q;
    assign pass     = pass_q;
    assign tt_out   = tt_q;
    assign err_mask = err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized and directed sweeps graded against a truth-table model
module tb_truth_table_sweeper;

    localparam int H = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start1 = 1'b0;
    logic [15:0] expected = '0, expected1 = '0, func = '0, func1 = '0;
    logic [3:0]  vec_out, vec_out1;
    logic        y_in, y_in1, busy, busy1, done, done1, pass, pass1;
    logic [15:0] tt_out, tt_out1, err_mask, err_mask1;
    int          checks = 0, passed = 0;

    always #5 clk = ~clk;

    assign y_in  = func[vec_out];
    assign y_in1 = func1[vec_out1];

    truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .vec_out(vec_out),
        .y_in(y_in), .busy(busy), .done(done), .pass(pass), .tt_out(tt_out), .err_mask(err_mask)
    );

    truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1), .vec_out(vec_out1),
        .y_in(y_in1), .busy(busy1), .done(done1), .pass(pass1), .tt_out(tt_out1), .err_mask(err_mask1)
    );

    // truth table of a named 4-input function: 0 = odd parity, 1 = 4-input AND, else constant 0
    function automatic logic [15:0] table_of(input int kind);
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < 16; i++)
            t[i] = (kind == 0) ? ($countones(4'(i)) % 2 == 1) : (kind == 1) ? (i == 15) : 1'b0;
        return t;
    endfunction

    // one full sweep; a second start with inj_ex can be injected at cycle inj after acceptance
    task automatic sweep(input logic [15:0] fn, input logic [15:0] ex, input int inj,
                         input logic [15:0] inj_ex, input string nm);
        int ve = 0, be = 0, de = 0;
        int last = 16 * H + 1;
        func = fn;
        expected = ex;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j <= last; j++) begin
            if (vec_out !== 4'((j < 16 * H) ? j / H : 15)) ve++;
            if (busy !== (j < 16 * H)) be++;
            if (done !== (j == last)) de++;
            start = (j == inj);
            expected = (j == inj) ? inj_ex : 16'($urandom);
            if (j < last) @(negedge clk);
        end
        checks++;
        if (ve != 0) $display("FAIL %s vec_seq: %0d bad cycles, required 0", nm, ve); else passed++;
        checks++;
        if (be != 0) $display("FAIL %s busy: %0d bad cycles, required 0", nm, be); else passed++;
        checks++;
        if (de != 0) $display("FAIL %s done: %0d bad cycles, required 0", nm, de); else passed++;
        checks++;
        if (pass !== (fn == ex)) $display("FAIL %s pass: got %b want %b", nm, pass, fn == ex); else passed++;
        checks++;
        if (tt_out !== fn) $display("FAIL %s tt_out: got %h want %h", nm, tt_out, fn); else passed++;
        checks++;
        if (err_mask !== (fn ^ ex)) $display("FAIL %s err_mask: got %h want %h", nm, err_mask, fn ^ ex); else passed++;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({vec_out, busy, done, pass} !== '0) $display("FAIL reset ctrl: got %b want 0", {vec_out, busy, done, pass}); else passed++;
        checks++;
        if (tt_out !== '0) $display("FAIL reset tt_out: got %h want 0", tt_out); else passed++;
        checks++;
        if (err_mask !== '0) $display("FAIL reset err_mask: got %h want 0", err_mask); else passed++;
        checks++;
        if ({vec_out1, busy1, done1, pass1, tt_out1, err_mask1} !== '0) $display("FAIL reset hold1: got %h want 0", {vec_out1, busy1, done1, pass1, tt_out1, err_mask1}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        sweep(table_of(0), 16'h6996, -1, '0, "parity");
        sweep(table_of(1), 16'h8000, -1, '0, "and4");
        sweep(table_of(2), 16'h6996, -1, '0, "zero");
    endtask

    task automatic test_back_to_back();
        sweep(table_of(0), 16'h6996, 20, 16'hFFFF, "b2b_busy");
        sweep(table_of(0), 16'h6996, 16 * H, 16'hFFFF, "b2b_report");
        @(negedge clk);
        checks++;
        if ({busy, done, vec_out} !== {1'b0, 1'b0, 4'hF}) $display("FAIL start_in_report: got busy=%b done=%b vec=%h want 0 0 f", busy, done, vec_out); else passed++;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        func = table_of(0);
        expected = 16'h6996;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({vec_out, busy, done, pass, tt_out, err_mask} !== '0) $display("FAIL reset_mid outputs: got %h want 0", {vec_out, busy, done, pass, tt_out, err_mask}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL reset_mid quiet: %0d active cycles, required 0", bad); else passed++;
        sweep(table_of(0), 16'h6996, -1, '0, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] fn, ex;
        for (int n = 0; n < 6; n++) begin
            fn = 16'($urandom);
            ex = ($urandom_range(0, 1) == 1) ? fn : fn ^ 16'($urandom_range(1, 65535));
            sweep(fn, ex, -1, '0, "random");
        end
    endtask

    task automatic test_hold1();
        int ve = 0, be = 0, de = 0;
        logic [15:0] fn;
        fn = table_of(0);
        func1 = fn;
        expected1 = 16'h6996;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j <= 17; j++) begin
            if (vec_out1 !== 4'((j < 16) ? j : 15)) ve++;
            if (busy1 !== (j < 16)) be++;
            if (done1 !== (j == 17)) de++;
            start1 = 1'b0;
            expected1 = 16'($urandom);
            if (j < 17) @(negedge clk);
        end
        checks++;
        if (ve != 0) $display("FAIL hold1 vec_seq: %0d bad cycles, required 0", ve); else passed++;
        checks++;
        if (be != 0) $display("FAIL hold1 busy: %0d bad cycles, required 0", be); else passed++;
        checks++;
        if (de != 0) $display("FAIL hold1 done: %0d bad cycles, required 0", de); else passed++;
        checks++;
        if ({pass1, tt_out1, err_mask1} !== {1'b1, fn, 16'h0}) $display("FAIL hold1 result: got %b %h %h want 1 %h 0", pass1, tt_out1, err_mask1, fn); else passed++;
    endtask

    initial begin
        test_reset();
        test_hold1();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
